// File: rtl/decryption_cfg_ctrl_if.sv
// decryption_cfg_ctrl_if: register access bus between the config sequencer and the register file
interface decryption_cfg_ctrl_if #(
  parameter int addr_witdth = 8,
  parameter int reg_width = 16
);
  logic [addr_witdth-1:0] addr;
  logic read;
  logic write;
  logic [reg_width-1:0] wdata;
  logic [reg_width-1:0] rdata;
  logic done;
  logic error;
  modport master (output addr, read, write, wdata, input rdata, done, error);
  modport slave (input addr, read, write, wdata, output rdata, done, error);
endinterface

// File: rtl/decryption_cfg_ctrl.sv
// decryption_cfg_ctrl: sequences key/select programming of the decryptors once they drain idle
module decryption_cfg_ctrl #(
  parameter int addr_witdth = 8,
  parameter int reg_width = 16,
  parameter logic [addr_witdth-1:0] SEL_ADDR = 8'h00,
  parameter logic [addr_witdth-1:0] CAESAR_ADDR = 8'h10,
  parameter logic [addr_witdth-1:0] SCY_ADDR = 8'h12,
  parameter logic [addr_witdth-1:0] ZIG_ADDR = 8'h14,
  parameter int TO_CYCLES = 15
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic cfg_req,
  input  logic [1:0] cfg_sel,
  input  logic [15:0] cfg_key,
  output logic cfg_ack,
  output logic cfg_err,
  input  logic busy,
  output logic stream_en,
  decryption_cfg_ctrl_if.master bus
);
  typedef enum logic [3:0] {IDLE, DRAIN, WR_KEY, W_KEY, WR_SEL, W_SEL, RD_SEL, W_RD, RESP} state_t;
  state_t state, state_n;
  logic [1:0] sel_q;
  logic [15:0] key_q;
  logic [3:0] cnt;
  logic idle_q, good, fail_n, timeout;
  logic [addr_witdth-1:0] key_addr;
  logic [reg_width-1:0] key_data;
  assign timeout = cnt == 4'(TO_CYCLES);
  assign key_addr = sel_q == 2'd0 ? CAESAR_ADDR : sel_q == 2'd1 ? SCY_ADDR : ZIG_ADDR;
  assign key_data = reg_width'(sel_q == 2'd2 ? {8'h00, key_q[7:0]} : key_q);
  // state register
  always_ff @(posedge clk_sys)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state; fail_n marks a transition into RESP that must report an error
  always_comb begin
    state_n = state;
    fail_n = 1'b0;
    case (state)
      IDLE: if (cfg_req) begin
        state_n = cfg_sel == 2'd3 ? RESP : DRAIN;
        fail_n = cfg_sel == 2'd3;
      end
      DRAIN: if (!busy && idle_q) state_n = WR_KEY;
        else if (busy && timeout) begin
          state_n = RESP;
          fail_n = 1'b1;
        end
      WR_KEY: state_n = W_KEY;
      WR_SEL: state_n = W_SEL;
      RD_SEL: state_n = W_RD;
      W_KEY, W_SEL, W_RD: if (bus.done) begin
        fail_n = bus.error || (state == W_RD && bus.rdata[1:0] != sel_q);
        state_n = fail_n || state == W_RD ? RESP : state == W_KEY ? WR_SEL : RD_SEL;
      end else if (timeout) begin
        state_n = RESP;
        fail_n = 1'b1;
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // registered outputs follow the state being entered, so strobes coincide with WR_*/RD_* states
  always_ff @(posedge clk_sys)
    if (!rst_n) begin
      sel_q <= '0;
      key_q <= '0;
      cnt <= '0;
      idle_q <= 1'b0;
      good <= 1'b0;
      stream_en <= 1'b0;
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      bus.addr <= '0;
      bus.read <= 1'b0;
      bus.write <= 1'b0;
      bus.wdata <= '0;
    end else begin
      cnt <= state_n != state ? 4'd0 : cnt == 4'hf ? cnt : cnt + 4'd1;
      idle_q <= state == DRAIN && !busy;
      if (state == IDLE && cfg_req) begin
        sel_q <= cfg_sel;
        key_q <= cfg_key;
      end
      bus.write <= state_n == WR_KEY || state_n == WR_SEL;
      bus.read <= state_n == RD_SEL;
      if (state_n == WR_KEY) begin
        bus.addr <= key_addr;
        bus.wdata <= key_data;
      end
      if (state_n == WR_SEL || state_n == RD_SEL) bus.addr <= SEL_ADDR;
      if (state_n == WR_SEL) bus.wdata <= reg_width'(sel_q);
      cfg_ack <= state_n == RESP && !fail_n;
      cfg_err <= state_n == RESP && fail_n;
      if (state == RESP) begin
        stream_en <= cfg_ack || good;
        good <= cfg_ack || good;
      end else if (state == IDLE && state_n == DRAIN) stream_en <= 1'b0;
    end
endmodule

// File: tb/tb_decryption_cfg_ctrl.sv
// tb_decryption_cfg_ctrl: scoreboard bench with a register-file responder and a job-level reference model
module tb_decryption_cfg_ctrl;
  localparam int TO = 15;
  localparam logic [7:0] A_SEL = 8'h00, A_CAE = 8'h10, A_SCY = 8'h12, A_ZIG = 8'h14;
  typedef struct { bit wr; logic [7:0] addr; logic [15:0] data; } acc_t;
  logic clk_sys = 1'b0, rst_n = 1'b0, cfg_req = 1'b0, busy = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [15:0] cfg_key = 16'h0;
  logic cfg_ack, cfg_err, stream_en;
  decryption_cfg_ctrl_if bus();
  decryption_cfg_ctrl dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .cfg_req(cfg_req), .cfg_sel(cfg_sel), .cfg_key(cfg_key),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .busy(busy), .stream_en(stream_en), .bus(bus)
  );
  always #5 clk_sys = ~clk_sys;
  acc_t exp_acc[$];
  bit exp_resp[$];
  int n_checks = 0, n_fail = 0, cyc = 0, nstrobes = 0, nresp = 0, resp_cyc = 0;
  int first_strobe_cyc = -1, rsp_mode = 0, rsp_dly = 1, busy_low_cyc = 0, busy_n = 0;
  bit good = 1'b0, prev_strobe = 1'b0;
  logic [15:0] regs [256];
  always @(posedge clk_sys) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // reference model: which bus accesses a job produces and whether it is acknowledged
  task automatic model_job(input logic [1:0] sel, input logic [15:0] key, input int mode,
                           input int busy_cyc, output int n_acc, output bit ok);
    acc_t a;
    n_acc = 0;
    ok = 1'b0;
    if (sel == 2'd3 || busy_cyc >= 20) begin
      exp_resp.push_back(1'b0);
      return;
    end
    a.wr = 1'b1;
    a.addr = sel == 2'd0 ? A_CAE : sel == 2'd1 ? A_SCY : A_ZIG;
    a.data = sel == 2'd2 ? {8'h00, key[7:0]} : key;
    exp_acc.push_back(a);
    n_acc = 1;
    if (mode == 1 || mode == 2) begin
      exp_resp.push_back(1'b0);
      return;
    end
    a.addr = A_SEL;
    a.data = {14'b0, sel};
    exp_acc.push_back(a);
    n_acc = 2;
    if (mode == 4) return;
    a.wr = 1'b0;
    exp_acc.push_back(a);
    n_acc = 3;
    ok = mode != 3;
    exp_resp.push_back(ok);
    good = good | ok;
  endtask
  // monitor: pops expectations whenever the DUT strobes the bus or answers a job
  always @(negedge clk_sys) begin
    acc_t e;
    if (bus.read || bus.write) begin
      chk("rd_wr_excl", 32'(bus.read & bus.write), 0);
      chk("strobe_1cyc", 32'(prev_strobe), 0);
      if (exp_acc.size() == 0) chk("unexpected_access", 1, 0);
      else begin
        e = exp_acc.pop_front();
        chk("acc_kind", 32'(bus.write), 32'(e.wr));
        chk("acc_addr", 32'(bus.addr), 32'(e.addr));
        if (e.wr) chk("acc_wdata", 32'(bus.wdata), 32'(e.data));
      end
      if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
      nstrobes++;
    end
    prev_strobe = bus.read | bus.write;
    if (cfg_ack || cfg_err) begin
      chk("ack_err_excl", 32'(cfg_ack & cfg_err), 0);
      if (exp_resp.size() == 0) chk("unexpected_resp", 1, 0);
      else chk("resp_ack", 32'(cfg_ack), 32'(exp_resp.pop_front()));
      resp_cyc = cyc;
      nresp++;
    end
  end
  // register file: done rsp_dly cycles after the strobe; modes inject errors, hangs, bad readback
  initial begin
    bus.done = 1'b0;
    bus.error = 1'b0;
    bus.rdata = 16'h0;
    for (int i = 0; i < 256; i++) regs[i] = 16'h0;
    forever begin
      @(negedge clk_sys);
      if (rst_n && (bus.read || bus.write)) begin
        automatic bit key_wr = bus.write && bus.addr != A_SEL;
        automatic bit hang = (rsp_mode == 2 && key_wr) || (rsp_mode == 4 && bus.write && !key_wr);
        automatic bit er = rsp_mode == 1 && key_wr;
        automatic logic [15:0] rd = bus.read ? regs[bus.addr] ^ (rsp_mode == 3 ? 16'h1 : 16'h0) : 16'h0;
        if (bus.write) regs[bus.addr] = bus.wdata;
        if (!hang) begin
          repeat (rsp_dly) @(posedge clk_sys);
          #1 bus.done = 1'b1;
          bus.error = er;
          bus.rdata = rd;
          @(posedge clk_sys);
          #1 bus.done = 1'b0;
          bus.error = 1'b0;
          bus.rdata = 16'h0;
        end
      end
    end
  end
  task automatic run_job(input logic [1:0] sel, input logic [15:0] key, input int mode, input int dly,
                         input int busy_cyc, output int lat, output int key_wait);
    int n_acc, s0, r0, t, req_c;
    bit ok, good0;
    good0 = good;
    model_job(sel, key, mode, busy_cyc, n_acc, ok);
    rsp_mode = mode;
    rsp_dly = dly;
    @(posedge clk_sys);
    #1;
    s0 = nstrobes;
    r0 = nresp;
    first_strobe_cyc = -1;
    cfg_req = 1'b1;
    cfg_sel = sel;
    cfg_key = key;
    req_c = cyc;
    if (busy_cyc > 0) begin
      busy = 1'b1;
      busy_n = busy_cyc;
      fork
        begin
          repeat (busy_n) @(posedge clk_sys);
          #1 busy = 1'b0;
          busy_low_cyc = cyc;
        end
      join_none
    end
    @(posedge clk_sys);
    #1 chk("stream_en_during", 32'(stream_en), sel == 2'd3 ? 32'(good0) : 0);
    t = 0;
    while (nresp == r0 && t < 80) begin
      @(posedge clk_sys);
      t++;
    end
    if (nresp == r0) chk("resp_timeout", 0, 1);
    #1 cfg_req = 1'b0;
    chk("n_access", 32'(nstrobes - s0), 32'(n_acc));
    chk("stream_en_after", 32'(stream_en), 32'(good));
    lat = resp_cyc - req_c + 1;
    key_wait = resp_cyc - first_strobe_cyc - 1;
    t = 0;
    while (busy && t < 64) begin
      @(posedge clk_sys);
      t++;
    end
    repeat (2) @(posedge clk_sys);
  endtask
  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ack"}, 32'(cfg_ack), 0);
    chk({tag, "_err"}, 32'(cfg_err), 0);
    chk({tag, "_stream_en"}, 32'(stream_en), 0);
    chk({tag, "_read"}, 32'(bus.read), 0);
    chk({tag, "_write"}, 32'(bus.write), 0);
    chk({tag, "_addr"}, 32'(bus.addr), 0);
    chk({tag, "_wdata"}, 32'(bus.wdata), 0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int lat, kw, n_acc, s0, t, r, mode;
    bit ok;
    repeat (3) @(posedge clk_sys);
    #1 chk_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    // req high in cycle 1, ack in cycle 10 with an ideal register file
    run_job(2'd0, 16'h0003, 0, 1, 0, lat, kw);
    chk("nominal_latency", 32'(lat), 10);
    run_job(2'd1, 16'h0403, 0, 1, 6, lat, kw);
    chk("drain_two_idle", 32'(first_strobe_cyc - busy_low_cyc), 2);
    run_job(2'd3, 16'hbeef, 0, 1, 0, lat, kw);
    chk("invalid_sel_fast", 32'(lat <= 3), 1);
    run_job(2'd0, 16'h00aa, 1, 1, 0, lat, kw);
    run_job(2'd2, 16'h1234, 2, 1, 0, lat, kw);
    chk("done_timeout_wait", 32'(kw), TO + 1);
    run_job(2'd2, 16'h1234, 0, 2, 0, lat, kw);
    run_job(2'd1, 16'h0101, 0, 1, 30, lat, kw);
    for (int j = 0; j < 24; j++) begin
      r = $urandom_range(0, 9);
      mode = r < 6 ? 0 : r == 6 ? 1 : r == 7 ? 3 : r == 8 ? 2 : 0;
      run_job(2'($urandom_range(0, 3)), 16'($urandom), mode, $urandom_range(1, 3),
              $urandom_range(0, 4), lat, kw);
    end
    // reset while waiting for the select write to complete
    model_job(2'd1, 16'h1234, 4, 0, n_acc, ok);
    rsp_mode = 4;
    rsp_dly = 1;
    @(posedge clk_sys);
    #1 s0 = nstrobes;
    cfg_req = 1'b1;
    cfg_sel = 2'd1;
    cfg_key = 16'h1234;
    t = 0;
    while (nstrobes < s0 + 2 && t < 40) begin
      @(posedge clk_sys);
      t++;
    end
    chk("reached_w_sel", 32'(nstrobes - s0), 2);
    #1 rst_n = 1'b0;
    cfg_req = 1'b0;
    @(posedge clk_sys);
    #1 chk_outputs_zero("midjob_reset");
    good = 1'b0;
    @(posedge clk_sys);
    #1 rst_n = 1'b1;
    chk("acc_queue_drained", 32'(exp_acc.size()), 0);
    chk("resp_queue_drained", 32'(exp_resp.size()), 0);
    run_job(2'd2, 16'h0005, 0, 1, 0, lat, kw);
    chk("post_reset_latency", 32'(lat), 10);
    repeat (3) @(posedge clk_sys);
    chk("final_acc_queue", 32'(exp_acc.size()), 0);
    chk("final_resp_queue", 32'(exp_resp.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
